// File: rtl/seg_scan_decoder.sv
// Receives the six-digit multiplexed 7-segment scan bus and rebuilds Hour/Minute/Second.
// Optional: define SEG_SCAN_DP_CHECK_EN to check the decimal point (lit only on positions 2 and 4).
module seg_scan_decoder #(
    parameter int STABLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] SEL,
    input  logic [7:0] DIG,
    output logic [7:0] Hour,
    output logic [7:0] Minute,
    output logic [7:0] Second,
    output logic       frame_valid,
    output logic       seg_err
);

    // state   | meaning
    // HUNT    | discard samples until an accepted position-0 digit
    // COLLECT | gather digits until all six positions are captured
    // DONE    | one cycle: outputs refreshed, frame_valid high

    typedef enum logic [1:0] {HUNT, COLLECT, DONE} state_t;

    state_t      state, state_nx;
    logic [13:0] prev_smp;
    logic [3:0]  stab_cnt, stab_cnt_nx;
    logic [4:0]  run_len;
    logic [5:0]  mask, mask_nx, mask_base;
    logic [3:0]  digit    [6];
    logic [3:0]  digit_nx [6];
    logic [5:0]  sel_act;
    logic [3:0]  seg_val;
    logic        sel_blank, sel_onehot, seg_ok, dp_ok;
    logic        accept, bad, wr_en, err_nx;

    function automatic logic [7:0] to_bin(input logic [3:0] ten, input logic [3:0] one);
        return {4'd0, ten} * 8'd10 + {4'd0, one};
    endfunction

    assign sel_act    = ~SEL;
    assign sel_blank  = (SEL == 6'h3F);
    assign sel_onehot = (sel_act != 6'd0) && ((sel_act & (sel_act - 6'd1)) == 6'd0);

    always_comb begin
        seg_ok  = 1'b1;
        seg_val = 4'd0;
        case (DIG[6:0])
            7'h40:   seg_val = 4'd0;
            7'h79:   seg_val = 4'd1;
            7'h24:   seg_val = 4'd2;
            7'h30:   seg_val = 4'd3;
            7'h19:   seg_val = 4'd4;
            7'h12:   seg_val = 4'd5;
            7'h02:   seg_val = 4'd6;
            7'h78:   seg_val = 4'd7;
            7'h00:   seg_val = 4'd8;
            7'h10:   seg_val = 4'd9;
            default: seg_ok  = 1'b0;
        endcase
    end

`ifdef SEG_SCAN_DP_CHECK_EN
    // Point is active-low: lit after the hour-one and minute-one digits only.
    assign dp_ok = (DIG[7] == ~(sel_act[2] | sel_act[4]));
`else
    assign dp_ok = 1'b1;
`endif

    // A held sample is accepted exactly once, on the cycle its run length reaches STABLE_CYC.
    assign run_len     = ({SEL, DIG} == prev_smp) ? ({1'b0, stab_cnt} + 5'd1) : 5'd0;
    assign accept      = !sel_blank && ((run_len + 5'd1) == 5'(STABLE_CYC));
    assign stab_cnt_nx = sel_blank ? 4'd0 : ((run_len > 5'd15) ? 4'd15 : run_len[3:0]);
    assign bad         = !sel_onehot || !seg_ok || !dp_ok;

    always_comb begin
        state_nx  = state;
        mask_base = (state == DONE) ? 6'd0 : mask;
        mask_nx   = mask_base;
        wr_en     = 1'b0;
        err_nx    = 1'b0;
        case (state)
            HUNT: begin
                if (accept && !bad && sel_act[0]) begin
                    wr_en    = 1'b1;
                    mask_nx  = 6'b000001;
                    state_nx = COLLECT;
                end
            end
            COLLECT, DONE: begin
                state_nx = COLLECT;
                if (accept && bad) begin
                    err_nx   = 1'b1;
                    mask_nx  = 6'd0;
                    state_nx = HUNT;
                end else if (accept) begin
                    wr_en   = 1'b1;
                    mask_nx = mask_base | sel_act;
                    if (mask_nx == 6'h3F) begin
                        state_nx = DONE;
                    end
                end
            end
            default: begin
                mask_nx  = 6'd0;
                state_nx = HUNT;
            end
        endcase
        for (int k = 0; k < 6; k++) begin
            digit_nx[k] = (wr_en && sel_act[k]) ? seg_val : digit[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HUNT;
            mask     <= 6'd0;
            stab_cnt <= 4'd0;
            prev_smp <= 14'd0;
            seg_err  <= 1'b0;
            Hour     <= 8'd0;
            Minute   <= 8'd0;
            Second   <= 8'd0;
            for (int k = 0; k < 6; k++) begin
                digit[k] <= 4'd0;
            end
        end else begin
            state    <= state_nx;
            mask     <= mask_nx;
            stab_cnt <= stab_cnt_nx;
            prev_smp <= {SEL, DIG};
            seg_err  <= err_nx;
            for (int k = 0; k < 6; k++) begin
                digit[k] <= digit_nx[k];
            end
            // Load on entry so the new values are visible during the DONE cycle.
            if (state_nx == DONE) begin
                Hour   <= to_bin(digit_nx[5], digit_nx[4]);
                Minute <= to_bin(digit_nx[3], digit_nx[2]);
                Second <= to_bin(digit_nx[1], digit_nx[0]);
            end
        end
    end

    assign frame_valid = (state == DONE);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed vector table, STABLE_CYC=3 hold sequences,
// and randomized scan traffic against a frame-level reference model (instances with STABLE_CYC 1 and 3).
module tb_seg_scan_decoder;

    typedef struct {
        bit         r;
        logic [5:0] sel;
        logic [7:0] dig;
        bit         fv;
        bit         err;
        int         h;
        int         m;
        int         s;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] SEL;
    logic [7:0] DIG;
    logic [7:0] h1, m1, s1, h3, m3, s3;
    logic       fv1, err1, fv3, err3;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    vec_t vecs[$];

    logic [6:0] seg_code [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    // frame 0: 12:34:56, frame 1: 23:59:48, frame 2: 12:34:56 with point lit on position 0
    logic [7:0] frames [3][6] = '{
        '{8'h82, 8'h92, 8'h19, 8'hB0, 8'h24, 8'hF9},
        '{8'h80, 8'h99, 8'h10, 8'h92, 8'h30, 8'hA4},
        '{8'h02, 8'h92, 8'h19, 8'hB0, 8'h24, 8'hF9}
    };

    int          stab_n [2] = '{1, 3};
    logic [13:0] m_prev [2];
    int          m_run  [2];
    bit          m_hunt [2];
    bit          m_done [2];
    bit          m_err  [2];
    bit          m_have [2][6];
    int          m_digit[2][6];
    int          m_h [2];
    int          m_m [2];
    int          m_s [2];

    always #5 clk = ~clk;

    seg_scan_decoder #(.STABLE_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .SEL(SEL), .DIG(DIG),
        .Hour(h1), .Minute(m1), .Second(s1), .frame_valid(fv1), .seg_err(err1)
    );

    seg_scan_decoder #(.STABLE_CYC(3)) dut3 (
        .clk(clk), .rst(rst), .SEL(SEL), .DIG(DIG),
        .Hour(h3), .Minute(m3), .Second(s3), .frame_valid(fv3), .seg_err(err3)
    );

    // Reference: runs of identical samples, a set of captured positions, and a hunting flag.
    task automatic model_step(input int i, input bit r, input logic [5:0] sel, input logic [7:0] dig);
        int zeros, p, v;
        bit acc, bad, full, was_done;
        if (r) begin
            m_prev[i] = 14'd0;
            m_run[i]  = 1;
            m_hunt[i] = 1'b1;
            m_done[i] = 1'b0;
            m_err[i]  = 1'b0;
            m_h[i] = 0;
            m_m[i] = 0;
            m_s[i] = 0;
            for (int k = 0; k < 6; k++) begin
                m_have[i][k]  = 1'b0;
                m_digit[i][k] = 0;
            end
            return;
        end
        if ({sel, dig} == m_prev[i]) m_run[i]++;
        else m_run[i] = 1;
        m_prev[i] = {sel, dig};
        acc = (sel != 6'h3F) && (m_run[i] == stab_n[i]);
        zeros = 0;
        p = -1;
        for (int k = 0; k < 6; k++) begin
            if (sel[k] == 1'b0) begin
                zeros++;
                p = k;
            end
        end
        v = -1;
        for (int d = 0; d < 10; d++) begin
            if (dig[6:0] == seg_code[d]) v = d;
        end
        bad = (zeros != 1) || (v < 0);
`ifdef SEG_SCAN_DP_CHECK_EN
        if (zeros == 1 && dig[7] != ((p == 2 || p == 4) ? 1'b0 : 1'b1)) bad = 1'b1;
`endif
        was_done  = m_done[i];
        m_done[i] = 1'b0;
        m_err[i]  = 1'b0;
        if (was_done) begin
            for (int k = 0; k < 6; k++) m_have[i][k] = 1'b0;
        end
        if (acc) begin
            if (m_hunt[i]) begin
                if (!bad && p == 0) begin
                    m_hunt[i]       = 1'b0;
                    m_have[i][0]    = 1'b1;
                    m_digit[i][0]   = v;
                end
            end else if (bad) begin
                m_err[i]  = 1'b1;
                m_hunt[i] = 1'b1;
                for (int k = 0; k < 6; k++) m_have[i][k] = 1'b0;
            end else begin
                m_digit[i][p] = v;
                m_have[i][p]  = 1'b1;
                full = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    if (!m_have[i][k]) full = 1'b0;
                end
                if (full) begin
                    m_done[i] = 1'b1;
                    m_h[i] = m_digit[i][5] * 10 + m_digit[i][4];
                    m_m[i] = m_digit[i][3] * 10 + m_digit[i][2];
                    m_s[i] = m_digit[i][1] * 10 + m_digit[i][0];
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [7:0] ah, input logic [7:0] am,
                         input logic [7:0] a_s, input logic afv, input logic aerr,
                         input int eh, input int em, input int es, input bit efv, input bit eerr);
        checks++;
        if (ah !== 8'(eh) || am !== 8'(em) || a_s !== 8'(es) || afv !== efv || aerr !== eerr) begin
            errors++;
            $display("FAIL %s: got H=%0d M=%0d S=%0d fv=%0b err=%0b, expected H=%0d M=%0d S=%0d fv=%0b err=%0b",
                     name, ah, am, a_s, afv, aerr, eh, em, es, efv, eerr);
        end
    endtask

    task automatic step(input bit r, input logic [5:0] s, input logic [7:0] d);
        rst = r;
        SEL = s;
        DIG = d;
        @(posedge clk);
        model_step(0, r, s, d);
        model_step(1, r, s, d);
        #1;
        cyc++;
        check($sformatf("model1 cyc%0d", cyc), h1, m1, s1, fv1, err1, m_h[0], m_m[0], m_s[0], m_done[0], m_err[0]);
        check($sformatf("model3 cyc%0d", cyc), h3, m3, s3, fv3, err3, m_h[1], m_m[1], m_s[1], m_done[1], m_err[1]);
    endtask

    task automatic add(input bit r, input logic [5:0] sel, input logic [7:0] dig, input bit fv,
                       input bit err, input int h, input int m, input int s);
        vec_t v;
        v.r = r; v.sel = sel; v.dig = dig; v.fv = fv; v.err = err; v.h = h; v.m = m; v.s = s;
        vecs.push_back(v);
    endtask

    // One full 0..5 scan; values before the last digit are the previously held ones.
    task automatic add_frame(input int f, input bit gaps, input int ph, input int pm, input int ps,
                             input int nh, input int nm, input int ns);
        logic [5:0] sk;
        for (int k = 0; k < 6; k++) begin
            sk = ~(6'b000001 << k);
            if (k == 5) add(1'b0, sk, frames[f][k], 1'b1, 1'b0, nh, nm, ns);
            else        add(1'b0, sk, frames[f][k], 1'b0, 1'b0, ph, pm, ps);
            if (gaps && k < 5) add(1'b0, 6'h3F, 8'hFF, 1'b0, 1'b0, ph, pm, ps);
        end
    endtask

    task automatic run_random(input int n);
        int p = 0;
        for (int it = 0; it < n; it++) begin
            int         roll, hold, v;
            logic [5:0] s;
            logic [7:0] d;
            bit         r;
            roll = int'($urandom_range(0, 99));
            v    = int'($urandom_range(0, 9));
            p    = (roll < 8) ? int'($urandom_range(0, 5)) : (p + 1) % 6;
            s    = ~(6'b000001 << p);
            d    = {((p == 2 || p == 4) ? 1'b0 : 1'b1), seg_code[v]};
            r    = 1'b0;
            hold = (roll < 3) ? 20 : int'($urandom_range(1, 4));
            if (roll >= 86 && roll < 89) d[7] = ~d[7];
            else if (roll >= 89 && roll < 93) d = 8'($urandom);
            else if (roll >= 93 && roll < 96) s = 6'($urandom);
            else if (roll >= 96 && roll < 99) s = 6'h3F;
            else if (roll == 99) begin
                r    = 1'b1;
                hold = 1;
            end
            repeat (hold) step(r, s, d);
        end
    endtask

    initial begin
        int         dh, dm, ds;
        logic [5:0] sk;

        add(1'b1, 6'h3F, 8'hFF, 1'b0, 1'b0, 0, 0, 0);
        add(1'b0, 6'h3F, 8'hFF, 1'b0, 1'b0, 0, 0, 0);
        add_frame(0, 1'b0, 0, 0, 0, 12, 34, 56);
        add(1'b0, 6'h3F, 8'hFF, 1'b0, 1'b0, 12, 34, 56);
        // scan starting mid-frame after reset: positions 3..5 are discarded
        add(1'b1, 6'h3F, 8'hFF, 1'b0, 1'b0, 0, 0, 0);
        add(1'b0, 6'h37, 8'hB0, 1'b0, 1'b0, 0, 0, 0);
        add(1'b0, 6'h2F, 8'h24, 1'b0, 1'b0, 0, 0, 0);
        add(1'b0, 6'h1F, 8'hF9, 1'b0, 1'b0, 0, 0, 0);
        add_frame(1, 1'b0, 0, 0, 0, 23, 59, 48);
        // illegal segment code mid-frame
        add(1'b0, 6'h3E, 8'h82, 1'b0, 1'b0, 23, 59, 48);
        add(1'b0, 6'h3D, 8'h92, 1'b0, 1'b0, 23, 59, 48);
        add(1'b0, 6'h3B, 8'h8E, 1'b0, 1'b1, 23, 59, 48);
        add(1'b0, 6'h3F, 8'hFF, 1'b0, 1'b0, 23, 59, 48);
        add_frame(0, 1'b0, 23, 59, 48, 12, 34, 56);
        // two strobes low, then a frame with blank gaps between digits
        add(1'b0, 6'h3E, 8'h80, 1'b0, 1'b0, 12, 34, 56);
        add(1'b0, 6'h3D, 8'h99, 1'b0, 1'b0, 12, 34, 56);
        add(1'b0, 6'h3C, 8'h80, 1'b0, 1'b1, 12, 34, 56);
        add(1'b0, 6'h3F, 8'hFF, 1'b0, 1'b0, 12, 34, 56);
        add_frame(1, 1'b1, 12, 34, 56, 23, 59, 48);
`ifdef SEG_SCAN_DP_CHECK_EN
        add(1'b0, 6'h3E, 8'h02, 1'b0, 1'b1, 23, 59, 48);
        for (int k = 1; k < 6; k++) begin
            sk = ~(6'b000001 << k);
            add(1'b0, sk, frames[2][k], 1'b0, 1'b0, 23, 59, 48);
        end
        dh = 23; dm = 59; ds = 48;
`else
        add_frame(2, 1'b0, 23, 59, 48, 12, 34, 56);
        dh = 12; dm = 34; ds = 56;
`endif
        add(1'b0, 6'h3F, 8'hFF, 1'b0, 1'b0, dh, dm, ds);

        foreach (vecs[n]) begin
            step(vecs[n].r, vecs[n].sel, vecs[n].dig);
            check($sformatf("vec%0d", n), h1, m1, s1, fv1, err1,
                  vecs[n].h, vecs[n].m, vecs[n].s, vecs[n].fv, vecs[n].err);
        end

        // STABLE_CYC=3 instance: two-cycle holds never accepted, three-cycle holds complete a frame
        step(1'b1, 6'h3F, 8'hFF);
        check("stab3 reset", h3, m3, s3, fv3, err3, 0, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            sk = ~(6'b000001 << k);
            repeat (2) begin
                step(1'b0, sk, frames[0][k]);
                check($sformatf("stab3 hold2 pos%0d", k), h3, m3, s3, fv3, err3, 0, 0, 0, 1'b0, 1'b0);
            end
        end
        for (int k = 0; k < 6; k++) begin
            sk = ~(6'b000001 << k);
            for (int j = 0; j < 3; j++) begin
                step(1'b0, sk, frames[0][k]);
                if (k == 5 && j == 2)
                    check("stab3 hold3 done", h3, m3, s3, fv3, err3, 12, 34, 56, 1'b1, 1'b0);
                else
                    check($sformatf("stab3 hold3 pos%0d.%0d", k, j), h3, m3, s3, fv3, err3, 0, 0, 0, 1'b0, 1'b0);
            end
        end
        step(1'b0, 6'h3F, 8'hFF);
        check("stab3 after", h3, m3, s3, fv3, err3, 12, 34, 56, 1'b0, 1'b0);

        run_random(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
